ex_mult_sequencer: RTL and testbench
====================================

// Module: ex_mult_sequencer
// PURPOSE
//  Multi-cycle shift-add multiply sequencer beside the EX-stage ALU for MULT/MULTU.
//  Latches operands on a start request, iterates one partial product per clock and
//  holds the pipeline (IF/ID/EX) with a stall until the product is ready.
//  Writes the 2*WIDTH-bit product to HI/LO registers and pulses a completion strobe.
//  Honours a pipeline flush: abort, no result.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count = WIDTH
//  CNT_W  6   counter width; must hold values 0..WIDTH
// PORTS
//  Clk       in   1        clock; all state updates on rising edge
//  Rst_n     in   1        asynchronous, active-low reset
//  Start_In  in   1        EX holds a MULT/MULTU this cycle (level, from decoded funct)
//  Signed_In in   1        1 = MULT (two's complement), 0 = MULTU
//  Flush_In  in   1        pipeline flush; aborts any operation
//  DataA_In  in   WIDTH    multiplicand (RS value)
//  DataB_In  in   WIDTH    multiplier (RT value)
//  Stall_Out out  1        freeze IF/ID/EX pipeline registers
//  Busy_Out  out  1        state == BUSY
//  Done_Out  out  1        one-cycle strobe, HI/LO newly valid
//  Hi_Out    out  WIDTH    upper product half (HI register)
//  Lo_Out    out  WIDTH    lower product half (LO register)
// BEHAVIOUR
//  Reset (async, Rst_n=0): state=IDLE, counter=0, Hi_Out=0, Lo_Out=0, Done_Out=0,
//   Busy_Out=0, internal accumulator/operands=0. Stall_Out=0 while Rst_n=0.
//  States: IDLE, BUSY, DONE.
//  IDLE: Start_In=1 & Flush_In=0 -> latch |A|,|B|, neg = Signed_In & (A[W-1]^B[W-1]),
//   acc=0, counter=WIDTH, go BUSY. Otherwise stay IDLE.
//  BUSY: each edge: if mplier[0] acc_hi += mcand (WIDTH+1-bit add, carry kept);
//   shift {carry,acc,mplier} right 1; counter -= 1. At edge where counter goes 1->0:
//   {Hi,Lo} = neg ? -product : product (2*WIDTH two's complement), go DONE.
//  DONE: Done_Out=1 for this cycle only. Start_In=1 -> accept new op (as IDLE), go
//   BUSY (back-to-back); else go IDLE.
//  Stall_Out (combinational) = (state==IDLE|DONE) & Start_In & ~Flush_In
//   | (state==BUSY & ~Flush_In). Low in the DONE cycle unless a new op starts.
//  Latency: start edge E0; BUSY edges E1..EWIDTH; DONE cycle follows EWIDTH.
//   Stall high for WIDTH+1 cycles; Done_Out high in cycle WIDTH+1 after E0.
//  Fixed latency: zero operands do not shorten the sequence.
//  Signed magnitude: -2^(W-1) magnitude is 2^(W-1); fits unsigned W bits, no overflow.
//  Flush_In=1 in any state: next edge -> IDLE, counter=0, HI/LO unchanged, no Done.
//   Flush beats Start in the same cycle.
//  Start_In while BUSY: ignored; the pipeline is stalled, so the request is the same
//   instruction.
//  Hi_Out/Lo_Out hold their value until the next completed operation.
//  Async reset mid-BUSY: immediate return to reset values; the operation is lost.
// TESTING
//  1 MULTU A=0x0000_0003 B=0x0000_0005 -> Stall 33 cycles, Done pulse once,
//    Hi=0x0, Lo=0xF
//  2 MULT A=0xFFFF_FFFF(-1) B=0x0000_0002 -> Hi=0xFFFF_FFFF, Lo=0xFFFF_FFFE;
//    MULTU same -> Hi=0x1, Lo=0xFFFF_FFFE
//  3 MULT A=B=0x8000_0000 -> Hi=0x4000_0000, Lo=0x0; A=0 B=0x1234 -> 0, latency 33
//  4 Flush_In on 10th BUSY cycle -> IDLE next edge, no Done, HI/LO keep prior values
//  5 Start held in DONE -> second op starts with no IDLE gap; Done pulses twice
//    (cycles 33 and 66); Stall low only in DONE cycles without Start
//  6 Rst_n=0 mid-BUSY -> all outputs 0 immediately; release then Start -> normal
//    33-cycle op

Source files
------------

// File: rtl/ex_mult_sequencer_if.sv
// Operand/result bundle between the EX stage and the multiply sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface ex_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start_In;
  logic             Signed_In;
  logic             Flush_In;
  logic [WIDTH-1:0] DataA_In;
  logic [WIDTH-1:0] DataB_In;
  logic             Stall_Out;
  logic             Busy_Out;
  logic             Done_Out;
  logic [WIDTH-1:0] Hi_Out;
  logic [WIDTH-1:0] Lo_Out;

  modport master (
    output Start_In, Signed_In, Flush_In, DataA_In, DataB_In,
    input  Stall_Out, Busy_Out, Done_Out, Hi_Out, Lo_Out
  );

  modport slave (
    input  Start_In, Signed_In, Flush_In, DataA_In, DataB_In,
    output Stall_Out, Busy_Out, Done_Out, Hi_Out, Lo_Out
  );
endinterface

// File: rtl/ex_mult_sequencer.sv
// Shift-add MULT/MULTU sequencer: WIDTH BUSY cycles plus one DONE cycle, fixed latency.
// Stalls IF/ID/EX from the start request until the product lands in HI/LO; flush aborts.
module ex_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  ex_mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     acc, mplier, mcand;
  logic                 neg;
  logic [WIDTH-1:0]     hi, lo;

  logic                 accept;
  logic                 last;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_sh, mpl_sh;
  logic [2*WIDTH-1:0]   prod, res;
  logic [WIDTH-1:0]     abs_a, abs_b;

  always_comb begin
    state_nxt = state;
    accept    = (state != BUSY) && bus.Start_In && !bus.Flush_In;
    last      = (state == BUSY) && (cnt == CNT_W'(1));
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.Flush_In) state_nxt = IDLE;
  end

  // One partial product per clock: conditional add into the upper half, then a
  // right shift of {carry, acc, mplier} so the product accumulates in place.
  always_comb begin
    sum    = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_sh = sum[WIDTH:1];
    mpl_sh = {sum[0], mplier[WIDTH-1:1]};
    prod   = {acc_sh, mpl_sh};
    res    = neg ? -prod : prod;
    abs_a  = (bus.Signed_In && bus.DataA_In[WIDTH-1]) ? -bus.DataA_In : bus.DataA_In;
    abs_b  = (bus.Signed_In && bus.DataB_In[WIDTH-1]) ? -bus.DataB_In : bus.DataB_In;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      if (bus.Flush_In) begin
        cnt <= '0;
      end else if (accept) begin
        mcand  <= abs_a;
        mplier <= abs_b;
        acc    <= '0;
        neg    <= bus.Signed_In & (bus.DataA_In[WIDTH-1] ^ bus.DataB_In[WIDTH-1]);
        cnt    <= CNT_W'(WIDTH);
      end else if (state == BUSY) begin
        acc    <= acc_sh;
        mplier <= mpl_sh;
        cnt    <= cnt - CNT_W'(1);
        if (last) {hi, lo} <= res;
      end
    end
  end

  // Gated by reset so a held Start_In cannot freeze the pipeline during reset.
  assign bus.Stall_Out = Rst_n & (accept | ((state == BUSY) & ~bus.Flush_In));
  assign bus.Busy_Out  = (state == BUSY);
  assign bus.Done_Out  = (state == DONE);
  assign bus.Hi_Out    = hi;
  assign bus.Lo_Out    = lo;

endmodule

// File: tb/tb_ex_mult_sequencer.sv
// Directed bench for ex_mult_sequencer: latency, signed/unsigned products, flush,
// back-to-back issue and asynchronous reset.
module tb_ex_mult_sequencer;

  logic Clk;
  logic Rst_n;
  int   vectors;
  int   errs;

  ex_mult_sequencer_if #(.WIDTH(32)) bus ();

  ex_mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from the current cycle (cycle 0) and watch 40 cycles.
  task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int st, dn, dc;
    logic [31:0] h, l;
    bus.Signed_In = sg;
    bus.DataA_In  = a;
    bus.DataB_In  = b;
    bus.Start_In  = 1'b1;
    st = 0; dn = 0; dc = -1; h = '0; l = '0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Done_Out) begin
        dn++;
        dc = c;
        h  = bus.Hi_Out;
        l  = bus.Lo_Out;
        bus.Start_In = 1'b0;
      end
      #1;
      if (bus.Stall_Out) st++;
      @(posedge Clk); #1;
    end
    chk({tag, " stall_cycles"}, st, 33);
    chk({tag, " done_count"}, dn, 1);
    chk({tag, " done_cycle"}, dc, 33);
    chk({tag, " hi"}, h, eh);
    chk({tag, " lo"}, l, el);
  endtask

  initial begin
    int dn, dc1, dc2, st;
    logic [31:0] h1, l1;
    vectors = 0;
    errs    = 0;

    // Reset held with a start request pending: everything quiet.
    Rst_n         = 1'b0;
    bus.Start_In  = 1'b1;
    bus.Signed_In = 1'b0;
    bus.Flush_In  = 1'b0;
    bus.DataA_In  = 32'd3;
    bus.DataB_In  = 32'd5;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst stall", bus.Stall_Out, 0);
    chk("rst busy",  bus.Busy_Out,  0);
    chk("rst done",  bus.Done_Out,  0);
    chk("rst hi",    bus.Hi_Out,    0);
    chk("rst lo",    bus.Lo_Out,    0);
    bus.Start_In = 1'b0;
    Rst_n        = 1'b1;
    @(posedge Clk); #1;

    run_op("multu 3x5",   1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0,         32'hF);
    chk("idle after op", bus.Busy_Out, 0);
    run_op("mult -1x2",   1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu ffx2",  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult 0x1234", 1'b1, 32'h0000_0000, 32'h0000_1234, 32'h0,         32'h0);
    run_op("mult min^2",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    // Flush on the 10th BUSY cycle.
    bus.Signed_In = 1'b0;
    bus.DataA_In  = 32'd11;
    bus.DataB_In  = 32'd13;
    bus.Start_In  = 1'b1;
    repeat (10) begin @(posedge Clk); #1; end
    bus.Start_In = 1'b0;
    bus.Flush_In = 1'b1;
    #1;
    chk("flush busy before", bus.Busy_Out, 1);
    chk("flush stall",       bus.Stall_Out, 0);
    @(posedge Clk); #1;
    bus.Flush_In = 1'b0;
    chk("flush to idle", bus.Busy_Out, 0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Done_Out) dn++;
      @(posedge Clk); #1;
    end
    chk("flush no done", dn, 0);
    chk("flush hi kept", bus.Hi_Out, 32'h4000_0000);
    chk("flush lo kept", bus.Lo_Out, 32'h0);

    // Flush and start in the same idle cycle: flush wins.
    bus.Start_In = 1'b1;
    bus.Flush_In = 1'b1;
    #1;
    chk("flush vs start stall", bus.Stall_Out, 0);
    @(posedge Clk); #1;
    chk("flush vs start busy", bus.Busy_Out, 0);
    bus.Start_In = 1'b0;
    bus.Flush_In = 1'b0;
    @(posedge Clk); #1;

    // Back-to-back: 7*9 unsigned, then -3*5 signed issued from the DONE cycle.
    bus.Signed_In = 1'b0;
    bus.DataA_In  = 32'd7;
    bus.DataB_In  = 32'd9;
    bus.Start_In  = 1'b1;
    dn = 0; dc1 = -1; dc2 = -1; st = 0; h1 = '0; l1 = '0;
    for (int c = 0; c < 80; c++) begin
      if (bus.Done_Out) begin
        dn++;
        if (dn == 1) begin
          dc1 = c;
          h1  = bus.Hi_Out;
          l1  = bus.Lo_Out;
          bus.Signed_In = 1'b1;
          bus.DataA_In  = 32'hFFFF_FFFD;
          bus.DataB_In  = 32'd5;
        end else begin
          dc2 = c;
          bus.Start_In = 1'b0;
        end
      end
      #1;
      if (bus.Stall_Out) st++;
      @(posedge Clk); #1;
    end
    chk("b2b done count",  dn, 2);
    chk("b2b done1 cycle", dc1, 33);
    chk("b2b done2 cycle", dc2, 66);
    chk("b2b stall count", st, 66);
    chk("b2b hi1", h1, 32'h0);
    chk("b2b lo1", l1, 32'd63);
    chk("b2b hi2", bus.Hi_Out, 32'hFFFF_FFFF);
    chk("b2b lo2", bus.Lo_Out, 32'hFFFF_FFF1);

    // Asynchronous reset in the middle of BUSY.
    bus.Signed_In = 1'b0;
    bus.DataA_In  = 32'd7;
    bus.DataB_In  = 32'd9;
    bus.Start_In  = 1'b1;
    repeat (10) begin @(posedge Clk); #1; end
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst busy",  bus.Busy_Out,  0);
    chk("arst stall", bus.Stall_Out, 0);
    chk("arst done",  bus.Done_Out,  0);
    chk("arst hi",    bus.Hi_Out,    0);
    chk("arst lo",    bus.Lo_Out,    0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    run_op("post-reset 3x5", 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
